// File: rtl/epass_lookup_arbiter.sv
// epass_lookup_arbiter: round-robin arbiter that shares one E-pass account
// lookup engine among N_LANE toll-lane controllers. One transaction is in
// flight at a time; each is supervised by a timeout. Per-lane verdicts use
// the valid_Epass encoding: 10 pass, 01 reject, 00 pending, 11 error/hold.
module epass_lookup_arbiter #(
    parameter int N_LANE  = 4,
    parameter int TAG_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_LANE-1:0]         lane_req_i,
    input  logic [N_LANE*TAG_W-1:0]   lane_tag_i,
    output logic [N_LANE-1:0]         lane_ack_o,
    output logic [2*N_LANE-1:0]       lane_result_o,
    output logic                      eng_valid_o,
    output logic [TAG_W-1:0]          eng_tag_o,
    input  logic                      eng_ready_i,
    input  logic                      eng_rsp_valid_i,
    input  logic                      eng_rsp_ok_i,
    input  logic                      eng_rsp_err_i,
    output logic [7:0]                timeout_cnt_o
);

    localparam int IDX_W = $clog2(N_LANE);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LANE - 1);

    localparam logic [1:0] V_PEND = 2'b00;
    localparam logic [1:0] V_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [2*N_LANE-1:0] result_q, result_d;
    logic [7:0]          tocnt_q, tocnt_d;

    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [TAG_W-1:0]    pick_tag;

    // Engine response to lane verdict; an engine fault outranks an ok flag.
    function automatic logic [1:0] rsp_verdict(input logic ok, input logic err);
        if (err)     return 2'b11;
        else if (ok) return 2'b10;
        else         return 2'b01;
    endfunction

    // Timeout counter increment that sticks at its maximum.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round-robin pick: first requesting lane at or after ptr, wrapping.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_l;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N_LANE; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_LANE) idx = idx - N_LANE;
            idx_l = IDX_W'(idx);
            if (!pick_vld && lane_req_i[idx_l]) begin
                pick_vld = 1'b1;
                pick_idx = idx_l;
            end
        end
    end

    // Tag of the lane the round-robin pick points at.
    always_comb begin
        pick_tag = '0;
        for (int i = 0; i < N_LANE; i++) begin
            if (IDX_W'(i) == pick_idx) pick_tag = lane_tag_i[i*TAG_W +: TAG_W];
        end
    end

    // Transaction FSM next state, timer, verdict and timeout bookkeeping.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        tag_d    = tag_q;
        tmr_d    = tmr_q;
        result_d = result_q;
        tocnt_d  = tocnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d = pick_idx;
                    tag_d = pick_tag;
                    tmr_d = '0;
                    for (int i = 0; i < N_LANE; i++) begin
                        if (IDX_W'(i) == pick_idx) result_d[2*i +: 2] = V_PEND;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TMR_LAST) begin
                    for (int i = 0; i < N_LANE; i++) begin
                        if (IDX_W'(i) == gnt_q) result_d[2*i +: 2] = V_ERR;
                    end
                    tocnt_d = sat_inc(tocnt_q);
                    state_d = S_DONE;
                end else if (eng_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (eng_rsp_valid_i) begin
                    // A response in the timeout cycle still counts.
                    for (int i = 0; i < N_LANE; i++) begin
                        if (IDX_W'(i) == gnt_q)
                            result_d[2*i +: 2] = rsp_verdict(eng_rsp_ok_i, eng_rsp_err_i);
                    end
                    state_d = S_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    for (int i = 0; i < N_LANE; i++) begin
                        if (IDX_W'(i) == gnt_q) result_d[2*i +: 2] = V_ERR;
                    end
                    tocnt_d = sat_inc(tocnt_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            tag_q    <= '0;
            tmr_q    <= '0;
            result_q <= '0;
            tocnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            tag_q    <= tag_d;
            tmr_q    <= tmr_d;
            result_q <= result_d;
            tocnt_q  <= tocnt_d;
        end
    end

    // Ack pulse for the granted lane during the single DONE cycle.
    always_comb begin
        lane_ack_o = '0;
        if (state_q == S_DONE) begin
            for (int i = 0; i < N_LANE; i++) begin
                if (IDX_W'(i) == gnt_q) lane_ack_o[i] = 1'b1;
            end
        end
    end

    assign eng_valid_o   = (state_q == S_ISSUE);
    assign eng_tag_o     = tag_q;
    assign lane_result_o = result_q;
    assign timeout_cnt_o = tocnt_q;

endmodule

// File: tb/tb_epass_lookup_arbiter.sv
// Testbench for epass_lookup_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
module tb_epass_lookup_arbiter;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int TO = 64;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    lane_req;
    logic [N*TW-1:0] lane_tag;
    logic [N-1:0]    lane_ack;
    logic [2*N-1:0]  lane_result;
    logic            eng_valid;
    logic [TW-1:0]   eng_tag;
    logic            eng_ready;
    logic            eng_rsp_valid;
    logic            eng_rsp_ok;
    logic            eng_rsp_err;
    logic [7:0]      timeout_cnt;

    int vectors;
    int miscompares;
    int cyc;

    // Reference model state
    int         mptr;
    logic [1:0] mres [N];
    int         mto;

    epass_lookup_arbiter #(.N_LANE(N), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .lane_req_i      (lane_req),
        .lane_tag_i      (lane_tag),
        .lane_ack_o      (lane_ack),
        .lane_result_o   (lane_result),
        .eng_valid_o     (eng_valid),
        .eng_tag_o       (eng_tag),
        .eng_ready_i     (eng_ready),
        .eng_rsp_valid_i (eng_rsp_valid),
        .eng_rsp_ok_i    (eng_rsp_ok),
        .eng_rsp_err_i   (eng_rsp_err),
        .timeout_cnt_o   (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] exp_res();
        logic [2*N-1:0] r;
        for (int i = 0; i < N; i++) r[2*i +: 2] = mres[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mptr = 0;
        mto  = 0;
        for (int i = 0; i < N; i++) mres[i] = 2'b00;
    endtask

    // One full transaction starting from an IDLE cycle.
    // rd: ISSUE cycles with eng_ready low; rsd: cycles from accept to response.
    task automatic run_txn(input int rd, input int rsd, input bit ok, input bit err,
                           input bit noresp, input bit keep,
                           output int g, output int ack_cyc);
        int         gg;
        int         d;
        bit         tmo;
        logic [1:0] verdict;
        logic [TW-1:0] exp_tag;
        gg = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (gg < 0 && lane_req[idx]) gg = idx;
        end
        g = gg;
        ack_cyc = cyc;
        if (gg < 0) begin
            check("no_requester", 32'd0, 32'd1);
            step();
            return;
        end
        tmo     = noresp || (rd >= TO - 1) || (rd + rsd > TO - 1);
        d       = tmo ? TO : rd + rsd + 1;
        verdict = tmo ? 2'b11 : (err ? 2'b11 : (ok ? 2'b10 : 2'b01));
        exp_tag = lane_tag[gg*TW +: TW];
        mres[gg] = 2'b00;
        step();
        for (int o = 0; o <= d; o++) begin
            eng_ready = (o >= rd);
            if (!noresp && o == rd + rsd) begin
                eng_rsp_valid = 1'b1;
                eng_rsp_ok    = ok;
                eng_rsp_err   = err;
            end else begin
                eng_rsp_valid = (o < rd) ? 1'($urandom_range(0, 1)) : 1'b0;
                eng_rsp_ok    = 1'($urandom_range(0, 1));
                eng_rsp_err   = 1'($urandom_range(0, 1));
            end
            #1;
            if (o < d) begin
                check("eng_valid", eng_valid, (o <= rd && o <= TO - 1));
                if (o <= rd && o <= TO - 1) check("eng_tag", eng_tag, exp_tag);
                check("ack_early", lane_ack, 0);
                check("result_pending", lane_result, exp_res());
                check("timeout_cnt_hold", timeout_cnt, mto);
            end else begin
                mres[gg] = verdict;
                if (tmo && mto < 255) mto++;
                ack_cyc = cyc;
                check("ack", lane_ack, 32'd1 << gg);
                check("result", lane_result, exp_res());
                check("timeout_cnt", timeout_cnt, mto);
            end
            step();
        end
        if (!keep) lane_req[gg] = 1'b0;
        eng_ready     = 1'b0;
        eng_rsp_valid = 1'b0;
        mptr = (gg + 1) % N;
        check("ack_idle", lane_ack, 0);
        check("valid_idle", eng_valid, 0);
    endtask

    initial begin
        int g;
        int ac;
        int prev_ac;
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        lane_req      = '0;
        lane_tag      = '0;
        eng_ready     = 1'b0;
        eng_rsp_valid = 1'b0;
        eng_rsp_ok    = 1'b0;
        eng_rsp_err   = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) lane_tag[i*TW +: TW] = 16'h1000 + 16'(i);

        // Reset values
        step();
        step();
        check("rst_ack", lane_ack, 0);
        check("rst_result", lane_result, 0);
        check("rst_valid", eng_valid, 0);
        check("rst_tag", eng_tag, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        reset_n = 1'b1;
        step();

        // All lanes requesting continuously, alternating pass/reject
        lane_req = 4'b1111;
        prev_ac  = 0;
        for (int t = 0; t < 5; t++) begin
            run_txn(0, 1, (t % 2 == 0), 1'b0, 1'b0, 1'b1, g, ac);
            if (t > 0) check("ack_spacing", ac - prev_ac, 4);
            prev_ac = ac;
        end
        lane_req = '0;
        step();

        // Single lane 2, tag 0x1A2B
        lane_tag[2*TW +: TW] = 16'h1A2B;
        lane_req = 4'b0100;
        run_txn(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);

        // Engine never responds, then a stale response arrives
        lane_req = 4'b0001;
        run_txn(0, 1, 1'b1, 1'b0, 1'b1, 1'b0, g, ac);
        step(); step(); step(); step();
        eng_rsp_valid = 1'b1;
        eng_rsp_ok    = 1'b1;
        step();
        eng_rsp_valid = 1'b0;
        check("stale_ack", lane_ack, 0);
        check("stale_valid", eng_valid, 0);
        step();
        check("stale_result", lane_result, exp_res());
        check("stale_timeout_cnt", timeout_cnt, mto);

        // Ok and err together, response in the exact timeout cycle
        lane_req = 4'b0010;
        run_txn(0, 2, 1'b1, 1'b1, 1'b0, 1'b0, g, ac);
        lane_req = 4'b1000;
        run_txn(0, TO - 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);
        lane_req = 4'b0001;
        run_txn(10, TO - 11, 1'b0, 1'b0, 1'b0, 1'b0, g, ac);

        // Ready held low 10 cycles, and never ready (timeout in ISSUE)
        lane_req = 4'b0100;
        run_txn(10, 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);
        lane_req = 4'b1000;
        run_txn(70, 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);

        // Reset during WAIT of lane 1, ptr left at 2 beforehand
        lane_req = 4'b0010;
        run_txn(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);
        lane_req = 4'b0010;
        step();
        eng_ready = 1'b1;
        check("pre_rst_valid", eng_valid, 1);
        step();
        eng_ready   = 1'b0;
        lane_req[3] = 1'b1;
        check("pre_rst_wait", eng_valid, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", eng_valid, 0);
        check("mid_rst_ack", lane_ack, 0);
        check("mid_rst_result", lane_result, 0);
        check("mid_rst_timeout_cnt", timeout_cnt, 0);
        check("mid_rst_tag", eng_tag, 0);
        step();
        check("rst_hold_ack", lane_ack, 0);
        reset_n = 1'b1;
        run_txn(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, g, ac);
        run_txn(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, g, ac);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            int  rd;
            int  rsd;
            bit  ok;
            bit  err;
            bit  nr;
            bit  kp;
            for (int i = 0; i < N; i++) begin
                if (!lane_req[i] && $urandom_range(0, 1) == 1) begin
                    lane_tag[i*TW +: TW] = 16'($urandom_range(0, 65535));
                    lane_req[i] = 1'b1;
                end
            end
            if (lane_req == '0) lane_req[$urandom_range(0, N - 1)] = 1'b1;
            rd  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 2);
            rsd = $urandom_range(1, 4);
            ok  = 1'($urandom_range(0, 1));
            err = ($urandom_range(0, 4) == 0);
            nr  = ($urandom_range(0, 19) == 0);
            kp  = ($urandom_range(0, 3) == 0);
            run_txn(rd, rsd, ok, err, nr, kp, g, ac);
        end
        lane_req = '0;
        step();
        check("final_result", lane_result, exp_res());
        check("final_timeout_cnt", timeout_cnt, mto);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/epass_lookup_arbiter.md
# epass_lookup_arbiter

Round-robin arbiter that shares one E-pass account lookup engine among `N_LANE` toll-lane controllers. Each lane raises a request carrying the tag read at its gantry. The arbiter serialises the requests to the engine, supervises each transaction with a timeout, and returns a 2-bit verdict per lane. The verdict uses the encoding the lane controllers already consume on `valid_Epass`: 10 = pass (open barrier), 01 = reject, 00 = pending, 11 = error (hold).

## Interface
- `N_LANE`, 4, number of lane requesters (2..8)
- `TAG_W`, 16, tag/account id width
- `TIMEOUT`, 64, max cycles from grant to engine response (≥4)
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `lane_req`  in  N_LANE  level request per lane; held until that lane's ack
- `lane_tag`  in  N_LANE*TAG_W  tag of lane i at bits [i*TAG_W +: TAG_W]; stable while req high
- `lane_ack`  out  N_LANE  one-cycle pulse: verdict for lane i now valid
- `lane_result`  out  2*N_LANE  verdict of lane i at bits [2i +: 2]; held until next grant of lane i
- `eng_valid`  out  1  lookup request to engine
- `eng_tag`  out  TAG_W  tag under lookup
- `eng_ready`  in  1  engine accepts request when eng_valid & eng_ready
- `eng_rsp_valid`  in  1  engine response strobe
- `eng_rsp_ok`  in  1  account valid, balance sufficient
- `eng_rsp_err`  in  1  engine fault / unknown account
- `timeout_cnt`  out  8  saturating count of timed-out transactions

## Operation
- FSM states:
  - IDLE: if any `lane_req` set, grant the first requesting lane at or after `ptr` (wrapping N_LANE-1→0). Latch index g and `lane_tag[g]`. Clear `lane_result[g]` to 00. Clear the timer. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `eng_valid`=1, `eng_tag`=latched tag. On `eng_ready`, go to WAIT.
  - WAIT: on `eng_rsp_valid`, set verdict = `eng_rsp_err` ? 11 : (`eng_rsp_ok` ? 10 : 01) and go to DONE. Err takes priority over ok.
  - DONE: `lane_ack[g]`=1 for exactly this cycle. `lane_result[g]` already holds the verdict. `ptr` ← (g+1) mod N_LANE. Go to IDLE.
- Timer:
  - Counts every cycle in ISSUE and WAIT, width $clog2(TIMEOUT).
  - When the count reaches TIMEOUT-1 in ISSUE or WAIT with no accepted response that cycle, verdict = 11, `timeout_cnt` +1 (saturate at 255), go to DONE.
  - A response arriving in the same cycle as the timeout wins.
- `eng_rsp_valid` is ignored in IDLE, ISSUE and DONE. Stale responses after a timeout are discarded. The engine never responds in its accept cycle.
- Lanes drop `lane_req` on the edge after seeing `lane_ack`. A lane whose req stays high is treated as a new request, but only when `ptr` reaches it again.
- Only one lane is in flight at any time. Other lanes' results are untouched.
- Fairness: with all lanes requesting continuously, grants go 0,1,2,…,N-1,0. No lane waits more than N_LANE-1 transactions.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, `lane_ack` 0, `lane_result` all 00, `eng_valid` 0, `eng_tag` 0, `timeout_cnt` 0, timer 0.
- Reset mid-transaction aborts immediately: `eng_valid` drops asynchronously and no ack is issued.
- Best-case latency with `eng_ready` and the response each arriving in the first eligible cycle:
  - req sampled in IDLE at cycle 0
  - `eng_valid` in cycle 1 (accepted)
  - response in cycle 2
  - `lane_ack` in cycle 3
  - next grant evaluated in cycle 4
- Throughput: one transaction per 4 cycles minimum.
- `eng_valid`/`eng_tag` are stable from ISSUE entry until accept or timeout. They are never withdrawn except on timeout.
- `lane_result[g]` reads 00 from the cycle after the grant until the DONE cycle. It changes value in the DONE cycle.

## Test plan
- Single lane 2, tag 0x1A2B: `eng_ready`=1, response ok=1 two cycles later → `eng_tag`=0x1A2B in cycle 1; `lane_ack`=0100 in cycle 3; `lane_result[5:4]`=10; `ptr`=3.
- All 4 lanes requesting continuously, engine instant, alternating ok/reject → grant order 0,1,2,3,0. Results 10,01,10,01. Acks spaced 4 cycles apart.
- Engine never responds, TIMEOUT=64 → lane verdict 11 at cycle 64 after grant; `timeout_cnt`=1. A late `eng_rsp_valid` 5 cycles after the ack changes nothing.
- Response with ok=1 and err=1 together → verdict 11. Response in the exact timeout cycle → engine verdict used and `timeout_cnt` unchanged.
- `eng_ready` held low for 10 cycles → `eng_valid` and `eng_tag` steady throughout. Accept on cycle 11, ok → verdict 10.
- `reset_n` pulsed low during WAIT for lane 1 → all outputs return to reset values; no ack. After release with lane 1 still requesting → lane 1 is re-granted from `ptr`=0.
